// File: rtl/count_enable_gen.sv
// Enable strobe source for the T-flip-flop counter: divides Clk down to a one-cycle En
// every DIV cycles, with a synchronized, debounced pushbutton that toggles run/pause.
module count_enable_gen #(
    parameter int DIV          = 50_000_000,
    parameter int DEB_CYCLES   = 1_000_000,
    parameter bit RUN_AT_RESET = 1'b1
) (
    input  logic Clk,
    input  logic ClrN,
    input  logic KeyN,
    output logic En,
    output logic Running
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [PW-1:0] PCNT_LAST = PW'(DIV - 1);
    localparam logic [DW-1:0] DCNT_LAST = DW'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_CHK,
        PRESSED,
        RELEASE_CHK
    } deb_state_t;

    logic          key_meta;
    logic          key_s;
    deb_state_t    state;
    logic [DW-1:0] dcnt;
    logic [PW-1:0] pcnt;

    // Both flops reset to 1 so a reset looks like a released button.
    always_ff @(posedge Clk or negedge ClrN) begin
        if (!ClrN) begin
            key_meta <= 1'b1;
            key_s    <= 1'b1;
        end else begin
            key_meta <= KeyN;
            key_s    <= key_meta;
        end
    end

    // Running flips on the same edge the press is accepted.
    always_ff @(posedge Clk or negedge ClrN) begin
        if (!ClrN) begin
            state   <= RELEASED;
            dcnt    <= '0;
            Running <= RUN_AT_RESET;
        end else begin
            case (state)
                RELEASED: begin
                    if (!key_s) begin
                        state <= PRESS_CHK;
                        dcnt  <= '0;
                    end
                end
                PRESS_CHK: begin
                    if (key_s) begin
                        state <= RELEASED;
                    end else if (dcnt == DCNT_LAST) begin
                        state   <= PRESSED;
                        Running <= ~Running;
                    end else begin
                        dcnt <= dcnt + DW'(1);
                    end
                end
                PRESSED: begin
                    if (key_s) begin
                        state <= RELEASE_CHK;
                        dcnt  <= '0;
                    end
                end
                RELEASE_CHK: begin
                    if (!key_s) begin
                        state <= PRESSED;
                    end else if (dcnt == DCNT_LAST) begin
                        state <= RELEASED;
                    end else begin
                        dcnt <= dcnt + DW'(1);
                    end
                end
                default: begin
                    state <= RELEASED;
                    dcnt  <= '0;
                end
            endcase
        end
    end

    // pcnt freezes while paused so a resume finishes the partial period.
    always_ff @(posedge Clk or negedge ClrN) begin
        if (!ClrN) begin
            pcnt <= '0;
            En   <= 1'b0;
        end else begin
            En <= Running && (pcnt == PCNT_LAST);
            if (Running) begin
                if (pcnt == PCNT_LAST) begin
                    pcnt <= '0;
                end else begin
                    pcnt <= pcnt + PW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_count_enable_gen.sv
// Directed bench for count_enable_gen: DIV=4/DEB_CYCLES=8 instance plus a DIV=1 instance,
// with edge-numbered expectations worked out by hand.
module tb_count_enable_gen;

    logic Clk;
    logic ClrN;
    logic KeyN;
    logic En;
    logic Running;
    logic KeyN1;
    logic En1;
    logic Running1;

    int compared;
    int mismatched;
    int edgeNo;
    int enCount;
    logic prevEn;

    count_enable_gen #(
        .DIV(4),
        .DEB_CYCLES(8),
        .RUN_AT_RESET(1'b1)
    ) dut (
        .Clk(Clk),
        .ClrN(ClrN),
        .KeyN(KeyN),
        .En(En),
        .Running(Running)
    );

    count_enable_gen #(
        .DIV(1),
        .DEB_CYCLES(8),
        .RUN_AT_RESET(1'b1)
    ) dut_div1 (
        .Clk(Clk),
        .ClrN(ClrN),
        .KeyN(KeyN1),
        .En(En1),
        .Running(Running1)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", tag, actual, expected, edgeNo);
        end
    endtask

    // One rising edge, then settle; also counts En pulses and watches for back-to-back En.
    task automatic tick();
        @(posedge Clk);
        #1;
        edgeNo++;
        if (prevEn) checkOutput("en_twice", En, 1'b0);
        if (En) enCount++;
        prevEn = En;
    endtask

    task automatic runTo(input int target);
        while (edgeNo < target) tick();
    endtask

    task automatic applyStimulus(input logic key, input int untilEdge);
        KeyN = key;
        runTo(untilEdge);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        edgeNo     = 0;
        enCount    = 0;
        prevEn     = 1'b0;
        ClrN       = 1'b0;
        KeyN       = 1'b1;
        KeyN1      = 1'b1;
        #12;
        checkOutput("rst_en", En, 1'b0);
        checkOutput("rst_run", Running, 1'b1);
        checkOutput("rst_en_div1", En1, 1'b0);
        @(posedge Clk);
        #1;
        ClrN = 1'b1;

        // Free-running cadence: En after edges 4, 8, 12.
        runTo(3);
        checkOutput("t1_en_e3", En, 1'b0);
        runTo(4);
        checkOutput("t1_en_e4", En, 1'b1);
        runTo(5);
        checkOutput("t1_en_e5", En, 1'b0);
        runTo(8);
        checkOutput("t1_en_e8", En, 1'b1);
        runTo(12);
        checkOutput("t1_count", enCount, 3);
        checkOutput("t1_run", Running, 1'b1);

        // Clean press to pause (toggle 11 edges after first low), release, press to resume.
        applyStimulus(1'b0, 22);
        checkOutput("t2_run_e22", Running, 1'b1);
        runTo(23);
        checkOutput("t2_run_e23", Running, 1'b0);
        checkOutput("t2_count_e23", enCount, 5);
        runTo(42);
        applyStimulus(1'b1, 72);
        checkOutput("t2_run_paused", Running, 1'b0);
        checkOutput("t2_count_paused", enCount, 5);
        applyStimulus(1'b0, 83);
        checkOutput("t2_resume_run", Running, 1'b1);
        checkOutput("t2_resume_en_e83", En, 1'b0);
        runTo(84);
        checkOutput("t2_resume_en_e84", En, 1'b1);
        runTo(102);
        applyStimulus(1'b1, 120);
        checkOutput("t2_count_e120", enCount, 15);
        checkOutput("t2_run_e120", Running, 1'b1);

        // Bounce shorter than the debounce window must be ignored.
        applyStimulus(1'b0, 125);
        applyStimulus(1'b1, 127);
        applyStimulus(1'b0, 132);
        applyStimulus(1'b1, 160);
        checkOutput("t3_run", Running, 1'b1);
        checkOutput("t3_count", enCount, 25);

        // Accepted press with a 3-cycle high glitch while held: single toggle.
        applyStimulus(1'b0, 170);
        checkOutput("t4_run_e170", Running, 1'b1);
        runTo(171);
        checkOutput("t4_run_e171", Running, 1'b0);
        checkOutput("t4_count_e171", enCount, 27);
        runTo(175);
        applyStimulus(1'b1, 178);
        applyStimulus(1'b0, 193);
        applyStimulus(1'b1, 220);
        checkOutput("t4_run_e220", Running, 1'b0);
        checkOutput("t4_count_e220", enCount, 27);

        // Reset while paused mid-period and mid-PRESS_CHK, key kept held.
        applyStimulus(1'b0, 226);
        checkOutput("t5_pre_run", Running, 1'b0);
        ClrN = 1'b0;
        #1;
        checkOutput("t5_rst_en", En, 1'b0);
        checkOutput("t5_rst_run", Running, 1'b1);
        #1;
        ClrN    = 1'b1;
        edgeNo  = 0;
        enCount = 0;
        prevEn  = 1'b0;
        runTo(3);
        checkOutput("t5_en_r3", En, 1'b0);
        runTo(4);
        checkOutput("t5_en_r4", En, 1'b1);
        runTo(10);
        checkOutput("t5_run_r10", Running, 1'b1);
        runTo(11);
        checkOutput("t5_run_r11", Running, 1'b0);
        checkOutput("t5_count_r11", enCount, 2);
        checkOutput("t6_en1_r11", En1, 1'b1);

        // DIV=1 instance: En every cycle while running, drops one edge after the pause toggle.
        applyStimulus(1'b1, 20);
        KeyN1 = 1'b0;
        runTo(30);
        checkOutput("t6_run1_r30", Running1, 1'b1);
        checkOutput("t6_en1_r30", En1, 1'b1);
        runTo(31);
        checkOutput("t6_run1_r31", Running1, 1'b0);
        checkOutput("t6_en1_r31", En1, 1'b1);
        runTo(32);
        checkOutput("t6_en1_r32", En1, 1'b0);
        runTo(36);
        checkOutput("t6_en1_r36", En1, 1'b0);
        KeyN1 = 1'b1;
        runTo(40);
        checkOutput("t6_main_count", enCount, 2);
        checkOutput("t6_main_run", Running, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
